comp_serial_cascade: RTL and testbench
======================================

Name: comp_serial_cascade

Overview:
Sequential wide magnitude comparator built around a single 4-bit cascadable comparator stage (`comp`, 74HC85 behaviour).
- Compares two NIBBLES*4-bit operands one nibble per clock.
- Feeds each stage's FGT/FLE/FEQ back as the next nibble's IGT/ILE/IEQ, which replaces a chain of NIBBLES comparator chips.
- Sits between operand registers and control logic that needs a registered >, <, = verdict with a start/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; minimum 1; operand width W = 4*NIBBLES.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a comparison; sampled only in IDLE
- a  in  W  operand A, captured when start is accepted
- b  in  W  operand B, captured when start is accepted
- igt  in  1  external cascade "greater" input, captured with the operands
- ile  in  1  external cascade "less" input, captured with the operands
- ieq  in  1  external cascade "equal" input, captured with the operands
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse; result valid from this cycle on
- fgt  out  1  registered result A > B
- fle  out  1  registered result A < B
- feq  out  1  registered result A == B (cascade-qualified)

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0: state = IDLE; busy, done, fgt, fle, feq = 0; counter and operand/cascade registers = 0.
- FSM states are IDLE, RUN and DONE.
  - IDLE: if start = 1 at a clock edge, latch a, b, igt/ile/ieq into the cascade register, set cnt = 0, and go to RUN. Otherwise stay in IDLE.
  - RUN (default build, LSB first): present nibble cnt of the latched A/B and the cascade register to `comp`. At each edge, load the cascade register with the comp outputs and increment cnt. On the edge where cnt == NIBBLES-1, load fgt/fle/feq from the comp outputs and go to DONE.
  - DONE: done = 1 for exactly this cycle. Next state is IDLE. start is ignored in this cycle.
- Per-nibble rule, identical to `comp`:
  - A_nib > B_nib gives GT=1.
  - A_nib < B_nib gives LE=1.
  - Equal nibbles pass the cascade inputs through unchanged.
  - Non-one-hot cascade inputs therefore propagate verbatim.
- Latency (default build): start is sampled at edge 0; done is high in the cycle after edge NIBBLES. Back-to-back throughput is one comparison per NIBBLES+2 cycles.
- Results hold their value until the next DONE load. They are not cleared on start.
- start pulses while busy are dropped and not queued. Changes to a/b/i* while busy do not affect the result in flight.
- NIBBLES = 1: RUN lasts one cycle, and the result equals a single `comp` evaluation.
- Reset asserted mid-RUN aborts immediately. No done is produced for the aborted operation.

Optional Feature:
- Macro: COMP_EARLY_EXIT_EN.
- Defined:
  - RUN scans MSB nibble first.
  - The comp cascade inputs are tied to the latched external flags.
  - At the first edge where A_nib != B_nib, load that stage's result and go to DONE.
  - If all nibbles are equal, load the latched external flags on the cnt == NIBBLES-1 edge.
  - Latency is 1..NIBBLES RUN cycles, data dependent. Results are identical to the default build.
- Undefined: fixed NIBBLES-cycle LSB-first cascade as described above.

Decomposition:
- Package comp_pkg holds:
  - NIB_W = 4
  - state enum {IDLE, RUN, DONE}
  - cascade flag index constants GT_I/LE_I/EQ_I for the 3-bit flag vector
- Sub-module: one instance of the existing `comp` (4-bit 74HC85 stage).
- Nibble select, counter, cascade register and FSM live in comp_serial_cascade.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h1235, cascade 0/0/1, start pulse -> fle=1, fgt=0, feq=0. done is high in the cycle after the 4th edge following start; busy is high 5 cycles.
- a=b=16'hABCD, run three times with cascade 1/0/0, then 0/1/0, then 0/0/1 -> fgt=1, then fle=1, then feq=1 respectively; other flags 0.
- a=16'hF000, b=16'h0FFF -> fgt=1. With COMP_EARLY_EXIT_EN, done comes 1 RUN cycle after start; without it, 4 cycles.
- a=16'h0001, b=16'h0000, cascade 0/0/1 -> fgt=1. The LSB decision must carry through 3 equal upper nibbles (default build).
- start held high continuously, with a/b changed every cycle -> one done per NIBBLES+2 cycles. Each result matches the operands present on the accepting edge; start during RUN/DONE is ignored.
- Drop rst_n mid-RUN after 2 nibbles -> busy, done, fgt, fle, feq all 0 asynchronously with no done pulse. After release, a new start (a=16'h0005, b=16'h0005, ieq=1) -> feq=1.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types and constants for the serial cascaded magnitude comparator.
package comp_pkg;

   localparam int unsigned NIB_W = 4;

   // Bit positions inside the 3-bit cascade flag vector {gt, le, eq}
   localparam int unsigned GT_I = 2;
   localparam int unsigned LE_I = 1;
   localparam int unsigned EQ_I = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/comp_serial_cascade_if.sv
// Request/result bundle between control logic and comp_serial_cascade.
interface comp_serial_cascade_if
   import comp_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) ();

   localparam int unsigned W = NIB_W * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         igt;
   logic         ile;
   logic         ieq;
   logic         busy;
   logic         done;
   logic         fgt;
   logic         fle;
   logic         feq;

   modport master (
      output start, a, b, igt, ile, ieq,
      input  busy, done, fgt, fle, feq
   );

   modport slave (
      input  start, a, b, igt, ile, ieq,
      output busy, done, fgt, fle, feq
   );

endinterface

// File: rtl/comp.sv
// 4-bit cascadable magnitude comparator stage (74HC85 behaviour).
// Equal nibbles pass the cascade inputs through verbatim, one-hot or not.
module comp
   import comp_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             igt,
   input  logic             ile,
   input  logic             ieq,
   output logic             fgt_c,
   output logic             fle_c,
   output logic             feq_c
);

   // Local nibble decision overrides the cascade; ties defer to it
   always_comb begin
      fgt_c = igt;
      fle_c = ile;
      feq_c = ieq;
      if (a > b) begin
         fgt_c = 1'b1;
         fle_c = 1'b0;
         feq_c = 1'b0;
      end else if (a < b) begin
         fgt_c = 1'b0;
         fle_c = 1'b1;
         feq_c = 1'b0;
      end
   end

endmodule

// File: rtl/comp_serial_cascade.sv
// Sequential wide magnitude comparator: one comp stage reused one nibble
// per clock, with a start/done handshake and registered verdict.
// Optional macro COMP_EARLY_EXIT_EN: scan MSB first and stop at the first
// differing nibble; default is a fixed-length LSB-first cascade.
module comp_serial_cascade
   import comp_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   comp_serial_cascade_if.slave bus
);

   localparam int unsigned W     = NIB_W * NIBBLES;
   localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   nib_sel;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [2:0]         casc;
   logic [NIB_W-1:0]   a_nib;
   logic [NIB_W-1:0]   b_nib;
   logic [2:0]         res_c;
   logic               last_c;
   logic               accept_c;
   logic               finish_c;
   logic               busy_q;
   logic               done_q;
   logic               fgt_q;
   logic               fle_q;
   logic               feq_q;

   // Nibble ordering and the RUN termination condition
   always_comb begin
`ifdef COMP_EARLY_EXIT_EN
      nib_sel = LAST - cnt;
`else
      nib_sel = cnt;
`endif
      a_nib = a_q[nib_sel*NIB_W +: NIB_W];
      b_nib = b_q[nib_sel*NIB_W +: NIB_W];
`ifdef COMP_EARLY_EXIT_EN
      last_c = (a_nib != b_nib) || (cnt == LAST);
`else
      last_c = (cnt == LAST);
`endif
   end

   comp u_comp (
      .a     (a_nib),
      .b     (b_nib),
      .igt   (casc[GT_I]),
      .ile   (casc[LE_I]),
      .ieq   (casc[EQ_I]),
      .fgt_c (res_c[GT_I]),
      .fle_c (res_c[LE_I]),
      .feq_c (res_c[EQ_I])
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and control strobes
   always_comb begin
      state_nx = state;
      accept_c = 1'b0;
      finish_c = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept_c = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last_c) begin
               finish_c = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, nibble counter and cascade register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         casc <= '0;
         cnt  <= '0;
      end else if (accept_c) begin
         a_q        <= bus.a;
         b_q        <= bus.b;
         casc[GT_I] <= bus.igt;
         casc[LE_I] <= bus.ile;
         casc[EQ_I] <= bus.ieq;
         cnt        <= '0;
      end else if (state == RUN) begin
         cnt <= cnt + CNT_W'(1);
`ifndef COMP_EARLY_EXIT_EN
         casc <= res_c;
`endif
      end
   end

   // Registered status and verdict; verdict holds until the next finish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         fgt_q  <= 1'b0;
         fle_q  <= 1'b0;
         feq_q  <= 1'b0;
      end else begin
         busy_q <= (state_nx != IDLE);
         done_q <= (state_nx == DONE);
         if (finish_c) begin
            fgt_q <= res_c[GT_I];
            fle_q <= res_c[LE_I];
            feq_q <= res_c[EQ_I];
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.fgt  = fgt_q;
   assign bus.fle  = fle_q;
   assign bus.feq  = feq_q;

endmodule

// File: tb/tb_comp_serial_cascade.sv
// Directed, table-driven bench for comp_serial_cascade (NIBBLES = 4).
module tb_comp_serial_cascade;

   localparam int unsigned NIBBLES = 4;
`ifdef COMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int B2B_LAT = EARLY ? 1 : 4;
   localparam int B2B_P   = B2B_LAT + 2;
   localparam int B2B_J   = 3 * B2B_P;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  cas;
      logic [2:0]  exp;
      int          lat_d;
      int          lat_e;
      string       name;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   vec_t vecs[11];
   logic [15:0] oa[B2B_J+1];
   logic [15:0] ob[B2B_J+1];

   comp_serial_cascade_if #(.NIBBLES(NIBBLES)) bus ();

   comp_serial_cascade #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] flags();
      return {bus.fgt, bus.fle, bus.feq};
   endfunction

   // One full transaction: operands are scrambled and a stray start is
   // pulsed while busy to show neither affects the result in flight.
   task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] cas, input logic [2:0] exp,
                          input int lat, input string nm);
      int seen;
      bit busy_bad;
      seen = -1;
      busy_bad = 1'b0;
      @(negedge clk);
      bus.a = a; bus.b = b;
      {bus.igt, bus.ile, bus.ieq} = cas;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = ~a; bus.b = a;
      {bus.igt, bus.ile, bus.ieq} = ~cas;
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) @(negedge clk);
         bus.start = (k == 1);
         if (bus.done) begin
            seen = k;
            break;
         end
         if (!bus.busy) busy_bad = 1'b1;
      end
      bus.start = 1'b0;
      chk({nm, "_lat"}, 32'(seen), 32'(lat));
      chk({nm, "_flags"}, 32'(flags()), 32'(exp));
      chk({nm, "_busy"}, 32'(busy_bad), 32'd0);
      @(negedge clk);
      chk({nm, "_after"}, {27'd0, bus.done, bus.busy, flags()}, {27'd0, 2'b00, exp});
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      //              a         b        cas     exp    lat_d lat_e
      vecs[0]  = '{16'h1234, 16'h1235, 3'b001, 3'b010, 4, 4, "lsb_less"};
      vecs[1]  = '{16'hABCD, 16'hABCD, 3'b100, 3'b100, 4, 4, "eq_casc_gt"};
      vecs[2]  = '{16'hABCD, 16'hABCD, 3'b010, 3'b010, 4, 4, "eq_casc_le"};
      vecs[3]  = '{16'hABCD, 16'hABCD, 3'b001, 3'b001, 4, 4, "eq_casc_eq"};
      vecs[4]  = '{16'hF000, 16'h0FFF, 3'b001, 3'b100, 4, 1, "msb_gt"};
      vecs[5]  = '{16'h0001, 16'h0000, 3'b001, 3'b100, 4, 4, "lsb_carry"};
      vecs[6]  = '{16'h0000, 16'hFFFF, 3'b100, 3'b010, 4, 1, "all_less"};
      vecs[7]  = '{16'h8000, 16'h7FFF, 3'b010, 3'b100, 4, 1, "msb_bit"};
      vecs[8]  = '{16'h1111, 16'h1111, 3'b110, 3'b110, 4, 4, "non_onehot"};
      vecs[9]  = '{16'h1111, 16'h1111, 3'b000, 3'b000, 4, 4, "casc_zero"};
      vecs[10] = '{16'h4321, 16'h4311, 3'b010, 3'b100, 4, 3, "mid_gt"};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0; bus.b = '0;
      bus.igt = 1'b0; bus.ile = 1'b0; bus.ieq = 1'b0;
      #12;
      chk("reset", {27'd0, bus.busy, bus.done, flags()}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_cmp(vecs[i].a, vecs[i].b, vecs[i].cas, vecs[i].exp,
                 EARLY ? vecs[i].lat_e : vecs[i].lat_d, vecs[i].name);

      // start held high with operands changing every cycle
      for (int j = 0; j <= B2B_J; j++) begin
         int d;
         bit want;
         logic [2:0] e;
         @(negedge clk);
         if (j > 0) begin
            d = j - 1 - B2B_LAT;
            want = (d >= 0) && (d % B2B_P == 0) && (d / B2B_P < 3);
            chk("b2b_done", 32'(bus.done), 32'(want));
            if (want) begin
               e = {oa[d] > ob[d], oa[d] < ob[d], oa[d] == ob[d]};
               chk("b2b_flags", 32'(flags()), 32'(e));
            end
         end
         oa[j] = {4'(j), 12'(j * 13)};
         ob[j] = {4'(j) ^ 4'h5, 12'(j * 7)};
         bus.a = oa[j]; bus.b = ob[j];
         {bus.igt, bus.ile, bus.ieq} = 3'b001;
         bus.start = (j < B2B_J);
      end
      repeat (B2B_P) @(negedge clk);
      chk("b2b_idle", 32'(bus.busy), 32'd0);

      // Reset in the middle of RUN after two nibbles
      @(negedge clk);
      bus.a = 16'h1234; bus.b = 16'h1235;
      {bus.igt, bus.ile, bus.ieq} = 3'b001;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_abort_busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("abort_clear", {27'd0, bus.busy, bus.done, flags()}, 32'd0);
      begin
         bit saw_done;
         saw_done = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
         end
         rst_n = 1'b1;
         repeat (6) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
         end
         chk("abort_no_done", 32'(saw_done), 32'd0);
      end
      run_cmp(16'h0005, 16'h0005, 3'b001, 3'b001, 4, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
